// File: rtl/bg_rom_arbiter.sv
// bg_rom_arbiter: two-port round-robin arbiter feeding a shared synchronous background ROM
module bg_rom_arbiter #(
    parameter int ROM_DEPTH = 786432,
    parameter int AW        = 20,
    parameter int DW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] rom_address,
    input  logic [DW-1:0] rom_rgb
);
    localparam logic [AW:0] DEPTH = (AW+1)'(ROM_DEPTH);

    logic          ptr;
    logic          s1_valid, s1_tag, s1_oor;
    logic          s2_valid, s2_tag, s2_oor;
    logic [DW-1:0] hold0, hold1, rd;
    logic [AW-1:0] sel_addr;

    // ptr = 1 means port 1 was granted last, so port 0 wins the next tie
    assign gnt0     = !rst && req0 && (!req1 || ptr);
    assign gnt1     = !rst && req1 && (!req0 || !ptr);
    assign sel_addr = gnt1 ? addr1 : addr0;
    assign rd       = s2_oor ? '0 : rom_rgb;
    assign rvalid0  = s2_valid && !s2_tag;
    assign rvalid1  = s2_valid && s2_tag;
    assign rdata0   = rvalid0 ? rd : hold0;
    assign rdata1   = rvalid1 ? rd : hold1;

    // grant stage: latch the winner's address and tag, advance the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= 1'b1;
            rom_address <= '0;
            s1_valid    <= 1'b0;
            s1_tag      <= 1'b0;
            s1_oor      <= 1'b0;
        end else begin
            s1_valid <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                ptr         <= gnt1;
                rom_address <= sel_addr;
                s1_tag      <= gnt1;
                s1_oor      <= {1'b0, sel_addr} >= DEPTH;
            end
        end
    end

    // ROM access stage: follow the request while the ROM produces its word
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_tag   <= 1'b0;
            s2_oor   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_oor   <= s1_oor;
        end
    end

    // keep the last delivered word per port visible between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (rvalid0) hold0 <= rd;
            if (rvalid1) hold1 <= rd;
        end
    end
endmodule

// File: tb/tb_bg_rom_arbiter.sv
// tb_bg_rom_arbiter: directed checks of grants, pipeline latency, range masking and reset flush
module tb_bg_rom_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [19:0] addr0, addr1, rom_address;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [11:0] rdata0, rdata1, rom_rgb;
    logic [11:0] hold0 = '0, hold1 = '0;
    int          n_chk = 0, n_bad = 0;

    bg_rom_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .rom_address(rom_address), .rom_rgb(rom_rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [19:0] a);
        return 12'(a * 20'd7 + 20'h1A3);
    endfunction

    // synchronous ROM model: data one cycle after address
    always_ff @(posedge clk) rom_rgb <= rom_fn(rom_address);

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    task automatic step(input logic r, input logic q0, input logic [19:0] a0,
                        input logic q1, input logic [19:0] a1,
                        input logic eg0, input logic eg1,
                        input logic ev0, input logic [11:0] ed0,
                        input logic ev1, input logic [11:0] ed1,
                        input logic ca, input logic [19:0] ea);
        rst = r; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
        #1;
        chk("gnt0", 32'(gnt0), 32'(eg0));
        chk("gnt1", 32'(gnt1), 32'(eg1));
        chk("rvalid0", 32'(rvalid0), 32'(ev0));
        chk("rvalid1", 32'(rvalid1), 32'(ev1));
        if (ev0) hold0 = ed0;
        if (ev1) hold1 = ed1;
        chk("rdata0", 32'(rdata0), 32'(hold0));
        chk("rdata1", 32'(rdata1), 32'(hold1));
        if (ca) chk("rom_address", 32'(rom_address), 32'(ea));
        @(posedge clk);
        #1;
        if (r) begin
            hold0 = '0;
            hold1 = '0;
        end
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset state, request suppressed while in reset
        step(1, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 0);
        // single port 0 read of address 0, granted in first cycle after reset
        step(0, 1, 0, 0, 0,  1, 0,  0, 0, 0, 0,  0, 0);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 0);
        step(0, 0, 0, 0, 0,  0, 0,  1, rom_fn(0), 0, 0,  0, 0);
        // port 1 out-of-range read returns zero
        step(0, 0, 0, 1, 20'hC0000,  0, 1,  0, 0, 0, 0,  0, 0);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 20'hC0000);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, 12'h000,  0, 0);
        // port 1 granted last: contention alternates starting with port 0
        step(0, 1, 20'h100, 1, 20'h201,  1, 0,  0, 0, 0, 0,  0, 0);
        step(0, 1, 20'h102, 1, 20'h201,  0, 1,  0, 0, 0, 0,  1, 20'h100);
        step(0, 1, 20'h102, 1, 20'h203,  1, 0,  1, rom_fn(20'h100), 0, 0,  1, 20'h201);
        step(0, 1, 20'h104, 1, 20'h203,  0, 1,  0, 0, 1, rom_fn(20'h201),  1, 20'h102);
        step(0, 1, 20'h104, 1, 20'h205,  1, 0,  1, rom_fn(20'h102), 0, 0,  1, 20'h203);
        step(0, 0, 0, 1, 20'h205,  0, 1,  0, 0, 1, rom_fn(20'h203),  1, 20'h104);
        step(0, 0, 0, 0, 0,  0, 0,  1, rom_fn(20'h104), 0, 0,  1, 20'h205);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, rom_fn(20'h205),  1, 20'h205);
        // reset right after a grant flushes the in-flight read
        step(0, 1, 20'h0AB, 0, 0,  1, 0,  0, 0, 0, 0,  0, 0);
        step(1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 20'h0AB);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 0);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 0);
        // port 0 streams 16 back-to-back reads
        for (int i = 0; i < 18; i++)
            step(0, i < 16, 20'(i), 0, 0,  i < 16, 0,  i >= 2, rom_fn(20'(i - 2)), 0, 0,
                 i >= 1 && i <= 16, 20'(i - 1));
        // reset restores port 0 priority on the first tie
        step(1, 1, 20'h5, 1, 20'h6,  0, 0,  0, 0, 0, 0,  0, 0);
        step(0, 1, 20'h5, 1, 20'h6,  1, 0,  0, 0, 0, 0,  1, 0);
        step(0, 0, 0, 1, 20'h6,  0, 1,  0, 0, 0, 0,  1, 20'h5);
        step(0, 0, 0, 0, 0,  0, 0,  1, rom_fn(20'h5), 0, 0,  1, 20'h6);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 1, rom_fn(20'h6),  0, 0);
        step(0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  1, 20'h6);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/bg_rom_arbiter.md
BG_ROM_ARBITER -- requirements
Module: bg_rom_arbiter

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 786432, number of valid ROM words (1024x768 background).
REQ-002 SHALL have parameter AW, default 20, address width.
REQ-003 SHALL have parameter DW, default 12, pixel width (4-bit R,G,B).
REQ-004 clk  input  1  single system clock; all state on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0  input  1  port 0 read request; held with addr0 until granted.
REQ-007 addr0  input  AW  port 0 pixel address.
REQ-008 gnt0  output  1  port 0 request accepted this cycle.
REQ-009 rvalid0  output  1  port 0 read data valid, one-cycle pulse.
REQ-010 rdata0  output  DW  port 0 read data.
REQ-011 req1, addr1, gnt1, rvalid1, rdata1 SHALL mirror REQ-006..REQ-010 for port 1.
REQ-012 rom_address  output  AW  registered address to the shared synchronous ROM.
REQ-013 rom_rgb  input  DW  ROM data, valid one cycle after rom_address.

Function
REQ-014 gnt0/gnt1 SHALL be combinational from req0/req1 and the round-robin pointer; never both high.
REQ-015 Only one requester high -> that port granted the same cycle, regardless of pointer.
REQ-016 Both high -> grant the port not granted last (pointer); pointer updates only on a grant, to the granted port.
REQ-017 No request -> no grant; pointer, rom_address hold.
REQ-018 Requester SHALL keep req/addr stable until gnt; a request is consumed in its gnt cycle; req high after gnt is a new request.
REQ-019 Grant in cycle N -> rom_address = selected addr from cycle N+1; stage-1 registers valid, port tag, out-of-range flag (addr >= ROM_DEPTH).
REQ-020 Cycle N+2: rvalid of granted port high for exactly one cycle; rdata = rom_rgb, or 12'h000 if out-of-range flag set.
REQ-021 Fixed latency 2 cycles grant-to-rvalid; throughput one grant per cycle; back-to-back grants pipelined, responses in grant order.
REQ-022 No read-data backpressure; requester SHALL accept rvalid whenever it occurs.
REQ-023 rdataX SHALL hold its last value when rvalidX low; rvalid of the non-tagged port stays low.
REQ-024 Out-of-range address SHALL still be granted and consume one slot; rom_address carries it unchanged (ROM content irrelevant).
REQ-025 Both ports continuously requesting -> strict alternation 0,1,0,1...; neither port waits more than one cycle.

Reset
REQ-026 While rst high at a posedge: gnt0/gnt1 low, rvalid0/rvalid1 0, rdata0/rdata1 12'h000, rom_address 0, stage valids 0, pointer = port 1 last granted (port 0 wins first tie).
REQ-027 Reset mid-operation SHALL discard all in-flight reads: no rvalid in any cycle after rst deasserts unless a new grant occurs.
REQ-028 Grants SHALL be issued in the first cycle after rst deasserts if req is high.

Verification
REQ-029 After reset, req0=1 addr0=20'h00000 only -> gnt0 same cycle, rom_address=0 next cycle, rvalid0=1 rdata0=ROM[0] two cycles after grant.
REQ-030 req0 and req1 both held high 6 cycles, distinct addresses -> grants 0,1,0,1,0,1; rvalids follow same order each 2 cycles later with matching data.
REQ-031 req1 alone with addr1=20'hC0000 (786432) -> gnt1, rvalid1 after 2 cycles, rdata1=12'h000.
REQ-032 Port 1 granted, then both request next cycle -> port 0 granted first.
REQ-033 Grant on port 0, rst asserted next cycle for 1 cycle -> no rvalid0 after reset; all outputs at reset values.
REQ-034 Port 0 requests every cycle for 16 cycles, addresses 0..15 -> 16 consecutive rvalid0 pulses, rdata0=ROM[0..15] in order, no gaps.
